// File: rtl/coin_acceptor.sv
// coin_acceptor: front-end for the vending FSM.
// Detects rising edges on three debounced coin levels (1, 2 and 5 units).
// Accepted coins wait in one pending flag per denomination. They then move
// into a small FIFO and are replayed one at a time as timed one-hot codes on
// Money_in. A coin is rejected when acceptance is inhibited, when a coin of
// the same denomination is already pending, or when the queue is full.
// Optional feature: define COIN_TOTAL_EN to add the saturating credit_total
// output, which sums the value of every coin driven onto Money_in.

module coin_acceptor #(
    parameter int FIFO_DEPTH = 4,
    parameter int PULSE_LEN  = 2,
    parameter int GAP_LEN    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin1,
    input  logic       coin2,
    input  logic       coin5,
    input  logic       accept_en,
    output logic [2:0] Money_in,
    output logic       reject,
    output logic       fifo_full,
    output logic       busy
`ifdef COIN_TOTAL_EN
    ,
    output logic [7:0] credit_total
`endif
);

    // Pointer and occupancy widths. The occupancy counter needs one extra bit
    // so that it can represent a completely full queue.
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    // Output FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Channel vectors use the same bit order as the Money_in code:
    // bit 0 = 1 unit, bit 1 = 2 units, bit 2 = 5 units.
    logic [2:0]       w_level;
    logic [2:0]       w_rise;
    logic [2:0]       w_accept_set;
    logic             w_rise_reject;
    logic [2:0]       w_xfer;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic [2:0]       w_head;

    logic [2:0]       r_prev;
    logic [2:0]       r_pending;
    logic [2:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state;
    logic [TMR_W-1:0] r_tmr;
    logic [2:0]       r_money;
    logic             r_reject;

    assign w_level = {coin5, coin2, coin1};
    assign w_rise  = w_level & ~r_prev;

    // A rise is accepted only while acceptance is enabled and no coin of the
    // same denomination is already pending. Any other rise is rejected.
    assign w_accept_set  = w_rise & {3{accept_en}} & ~r_pending;
    assign w_rise_reject = |(w_rise & ({3{~accept_en}} | r_pending));

    // The full test uses the occupancy before this edge. A pop in the same
    // cycle does not make room for the coin being transferred.
    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push = (|w_xfer) && !w_full;
    assign w_drop = (|w_xfer) && w_full;
    assign w_pop  = (r_state == ST_IDLE) && (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];

    assign Money_in  = r_money;
    assign reject    = r_reject;
    assign fifo_full = w_full;
    assign busy      = (r_count != '0) || (r_state != ST_IDLE);

    // Pick the single pending flag that transfers this cycle (priority 5 > 2 > 1)
    always_comb begin
        w_xfer = 3'b000;
        if (r_pending[2]) begin
            w_xfer = 3'b100;
        end else if (r_pending[1]) begin
            w_xfer = 3'b010;
        end else if (r_pending[0]) begin
            w_xfer = 3'b001;
        end
    end

    // Previous-sample registers; reset loads the live levels so held coins are ignored
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev <= w_level;
        end else begin
            r_prev <= w_level;
        end
    end

    // Pending flags: clear the transferred or dropped flag, set newly accepted ones
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= 3'b000;
        end else begin
            r_pending <= (r_pending & ~w_xfer) | w_accept_set;
        end
    end

    // Single reject pulse covering rise rejects and queue-full drops of this edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_reject <= 1'b0;
        end else begin
            r_reject <= w_rise_reject | w_drop;
        end
    end

    // Queue storage; the contents are only meaningful under the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_xfer;
        end
    end

    // Queue pointers and occupancy; a push and a pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output FSM: drive each code for PULSE_LEN cycles, then hold zero for GAP_LEN cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_money <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_money <= w_head;
                        r_tmr   <= '0;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_tmr == TMR_W'(PULSE_LEN - 1)) begin
                        r_money <= 3'b000;
                        r_tmr   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_tmr == TMR_W'(GAP_LEN - 1)) begin
                        r_tmr   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                end
                default: begin
                    r_money <= 3'b000;
                    r_tmr   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef COIN_TOTAL_EN
    logic [7:0] r_credit;

    function automatic logic [7:0] coin_value(input logic [2:0] code);
        logic [7:0] v;
        v = 8'd0;
        if (code[2]) begin
            v = 8'd5;
        end else if (code[1]) begin
            v = 8'd2;
        end else if (code[0]) begin
            v = 8'd1;
        end
        return v;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Running credit: add the value of each coin as it is popped into DRIVE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_credit <= 8'd0;
        end else if (w_pop) begin
            r_credit <= sat_add(r_credit, coin_value(w_head));
        end
    end

    assign credit_total = r_credit;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: directed scenarios followed by randomized
// stimulus, checked each cycle against a transaction-level reference model
// built from pending flags, a coin queue and the timing of each pop.
`timescale 1ns/1ps

module tb_coin_acceptor;

    localparam int FIFO_DEPTH = 4;
    localparam int PULSE_LEN  = 2;
    localparam int GAP_LEN    = 2;

    logic       clk;
    logic       reset;
    logic       coin1;
    logic       coin2;
    logic       coin5;
    logic       accept_en;
    logic [2:0] Money_in;
    logic       reject;
    logic       fifo_full;
    logic       busy;
`ifdef COIN_TOTAL_EN
    logic [7:0] credit_total;
`endif

    coin_acceptor #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin1       (coin1),
        .coin2       (coin2),
        .coin5       (coin5),
        .accept_en   (accept_en),
        .Money_in    (Money_in),
        .reject      (reject),
        .fifo_full   (fifo_full),
        .busy        (busy)
`ifdef COIN_TOTAL_EN
        ,
        .credit_total(credit_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         m_edge = 0;
    bit [2:0]   m_prev;
    bit [2:0]   m_pend;
    int         m_q[$];
    bit         m_have;
    int         m_last_pop;
    logic [2:0] m_code;
    bit         m_rej;
    int         m_credit;

    // Observations gathered by each step
    logic [2:0] obs[$];
    logic [2:0] last_money;
    int         g_rej;
    bit         g_full_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, m_edge);
        end
    endtask

    function automatic void model_update();
        bit [2:0] lvl;
        bit [2:0] rise;
        bit [2:0] nxt;
        bit       full;
        bit       idle;
        int       xi;
        int       val;
        m_edge++;
        lvl = {coin5, coin2, coin1};
        if (!reset) begin
            m_pend = 3'b000;
            m_q.delete();
            m_have = 1'b0;
            m_rej = 1'b0;
            m_credit = 0;
            m_prev = lvl;
            return;
        end
        rise = lvl & ~m_prev;
        m_rej = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (rise[i] && (!accept_en || m_pend[i])) m_rej = 1'b1;
        end
        full = (m_q.size() == FIFO_DEPTH);
        xi = -1;
        for (int i = 0; i < 3; i++) begin
            if (m_pend[i]) xi = i;
        end
        idle = !m_have || (m_edge >= m_last_pop + PULSE_LEN + GAP_LEN + 1);
        nxt = m_pend;
        if (xi >= 0) begin
            nxt[xi] = 1'b0;
            if (full) m_rej = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (rise[i] && accept_en && !m_pend[i]) nxt[i] = 1'b1;
        end
        if (idle && m_q.size() > 0) begin
            m_code = 3'(m_q.pop_front());
            m_have = 1'b1;
            m_last_pop = m_edge;
            val = (m_code == 3'b100) ? 5 : (m_code == 3'b010) ? 2 : 1;
            m_credit = (m_credit + val > 255) ? 255 : m_credit + val;
        end
        if (xi >= 0 && !full) m_q.push_back(1 << xi);
        m_pend = nxt;
        m_prev = lvl;
    endfunction

    // One clock: advance the model at the edge, compare the outputs just after it
    task automatic step();
        logic [2:0] exp_money;
        logic       exp_busy;
        @(posedge clk);
        model_update();
        #1;
        exp_money = (m_have && (m_edge - m_last_pop < PULSE_LEN)) ? m_code : 3'b000;
        exp_busy  = (m_q.size() != 0) || (m_have && (m_edge < m_last_pop + PULSE_LEN + GAP_LEN));
        check("money", 32'(Money_in), 32'(exp_money));
        check("reject", 32'(reject), 32'(m_rej));
        check("fifo_full", 32'(fifo_full), 32'(m_q.size() == FIFO_DEPTH));
        check("busy", 32'(busy), 32'(exp_busy));
        check("onehot", 32'($countones(Money_in) <= 1), 32'd1);
`ifdef COIN_TOTAL_EN
        check("credit", 32'(credit_total), 32'(m_credit));
`endif
        if (Money_in != 3'b000 && last_money == 3'b000) obs.push_back(Money_in);
        last_money = Money_in;
        if (reject) g_rej++;
        if (fifo_full) g_full_seen = 1'b1;
    endtask

    task automatic clear_obs();
        obs.delete();
        g_rej = 0;
        g_full_seen = 1'b0;
    endtask

    // Burst of n coin1 rises spaced two cycles apart, then drain
    task automatic burst(input int n);
        int guard;
        clear_obs();
        for (int j = 0; j < n; j++) begin
            coin1 = 1'b1;
            step();
            coin1 = 1'b0;
            step();
        end
        guard = 0;
        while (busy && guard < 200) begin
            step();
            guard++;
        end
        check("burst_drain_timeout", 32'(guard < 200), 32'd1);
        for (int j = 0; j < 3; j++) step();
        check("burst_full_seen", 32'(g_full_seen), 32'd1);
        check("burst_accounting", 32'(obs.size() + g_rej), 32'(n));
    endtask

    initial begin
        logic [2:0] exp_seq [6];
        int         cnt_money;
        int         guard;

        reset = 1'b0;
        coin1 = 1'b0;
        coin2 = 1'b0;
        coin5 = 1'b0;
        accept_en = 1'b1;
        last_money = 3'b000;
        clear_obs();

        // Reset state
        step();
        step();
        check("rst_money", 32'(Money_in), 32'd0);
        check("rst_reject", 32'(reject), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        for (int j = 0; j < 3; j++) step();

        // Single coin: code appears two edges after the rise, two cycles wide
        exp_seq = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000};
        clear_obs();
        coin2 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            check("single_seq", 32'(Money_in), 32'(exp_seq[j]));
        end
        coin2 = 1'b0;
        for (int j = 0; j < 4; j++) step();
        check("single_reject", 32'(g_rej), 32'd0);

        // Simultaneous coins come out in priority order 5, 2, 1
        clear_obs();
        coin1 = 1'b1;
        coin2 = 1'b1;
        coin5 = 1'b1;
        step();
        coin1 = 1'b0;
        coin2 = 1'b0;
        coin5 = 1'b0;
        for (int j = 0; j < 25; j++) step();
        check("simul_count", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) begin
            check("simul_first", 32'(obs[0]), 32'b100);
            check("simul_second", 32'(obs[1]), 32'b010);
            check("simul_third", 32'(obs[2]), 32'b001);
        end
        check("simul_busy_low", 32'(busy), 32'd0);

        // Inhibit: one reject pulse, no code
        clear_obs();
        accept_en = 1'b0;
        cnt_money = 0;
        coin5 = 1'b1;
        step();
        coin5 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            if (Money_in != 3'b000) cnt_money++;
        end
        check("inhibit_rejects", 32'(g_rej), 32'd1);
        check("inhibit_money", 32'(cnt_money), 32'd0);
        accept_en = 1'b1;

        // Overflow bursts; the longer one forces queue-full drops
        burst(7);
        burst(12);

        // Reset while a code is being driven
        coin5 = 1'b1;
        step();
        coin5 = 1'b0;
        guard = 0;
        while (Money_in != 3'b100 && guard < 10) begin
            step();
            guard++;
        end
        check("drive_wait", 32'(Money_in), 32'b100);
        reset = 1'b0;
        step();
        check("rst_drive_money", 32'(Money_in), 32'd0);
        check("rst_drive_busy", 32'(busy), 32'd0);
`ifdef COIN_TOTAL_EN
        check("rst_drive_credit", 32'(credit_total), 32'd0);
`endif
        reset = 1'b1;
        step();

        // Coin held high through reset release is not counted
        coin1 = 1'b1;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        clear_obs();
        for (int j = 0; j < 8; j++) step();
        check("held_no_code", 32'(obs.size()), 32'd0);
        coin1 = 1'b0;
        step();
        coin1 = 1'b1;
        for (int j = 0; j < 8; j++) step();
        check("held_recount", 32'(obs.size()), 32'd1);
        if (obs.size() == 1) check("held_code", 32'(obs[0]), 32'b001);
        coin1 = 1'b0;
        step();

        // Randomized traffic
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 3) == 0) coin1 = ~coin1;
            if ($urandom_range(0, 4) == 0) coin2 = ~coin2;
            if ($urandom_range(0, 5) == 0) coin5 = ~coin5;
            accept_en = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
